// File: rtl/accel_avg_feeder_pkg.sv
// Shared definitions for the accelerometer averaging feeder: default
// parameter values and the request FSM state encoding.
package accel_avg_feeder_pkg;

    localparam int DEF_DW       = 16;
    localparam int DEF_AVG_LOG2 = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/accel_avg_feeder_axis_accum.sv
// One axis of the box-car averager. The accumulator is wide enough that
// a full window of extreme samples cannot overflow. The average of the
// window is offered combinationally on the closing sample.
module accel_avg_feeder_axis_accum
    import accel_avg_feeder_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 add,
    input  logic                 close,
    input  logic signed [DW-1:0] sample,
    output logic signed [DW-1:0] avg
);

    localparam int AW = DW + AVG_LOG2;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;

    // Running sum including the current sample; dropping the low bits is an
    // arithmetic right shift, i.e. floor division by the window length.
    assign sum = acc + {{AVG_LOG2{sample[DW-1]}}, sample};
    assign avg = sum[AW-1:AVG_LOG2];

    // Accumulate each sample; a closing sample restarts from zero so that
    // consecutive windows never share samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (add) begin
            if (close) begin
                acc <= '0;
            end else begin
                acc <= sum;
            end
        end
    end

endmodule

// File: rtl/accel_avg_feeder.sv
// Averages raw accelerometer samples over 2^AVG_LOG2 samples and hands each
// average to cordic_angle with a start/done handshake. A finished average
// waits in pending registers while the CORDIC is busy; if another window
// closes first, the pending average is replaced and counted as an overrun.
module accel_avg_feeder
    import accel_avg_feeder_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 smp_valid,
    input  logic signed [DW-1:0] ax,
    input  logic signed [DW-1:0] ay,
    input  logic signed [DW-1:0] az,
    output logic signed [DW-1:0] x,
    output logic signed [DW-1:0] y,
    output logic signed [DW-1:0] z,
    output logic                 cdra_start,
    input  logic                 cdra_done,
    output logic                 busy,
    output logic [7:0]           ovr_cnt
);

    feeder_state_t state;
    feeder_state_t state_nxt;

    logic [AVG_LOG2-1:0]  smp_cnt;
    logic                 win_close;
    logic                 issue;
    logic                 pend_v;
    logic signed [DW-1:0] avg_x, avg_y, avg_z;
    logic signed [DW-1:0] pend_x, pend_y, pend_z;

    assign win_close = smp_valid && (smp_cnt == '1);
    assign issue     = (state == IDLE) && pend_v;
    assign busy      = (state == BUSY);

    accel_avg_feeder_axis_accum #(.DW(DW), .AVG_LOG2(AVG_LOG2)) u_acc_x (
        .clk(clk), .rst(rst), .add(smp_valid), .close(win_close),
        .sample(ax), .avg(avg_x)
    );

    accel_avg_feeder_axis_accum #(.DW(DW), .AVG_LOG2(AVG_LOG2)) u_acc_y (
        .clk(clk), .rst(rst), .add(smp_valid), .close(win_close),
        .sample(ay), .avg(avg_y)
    );

    accel_avg_feeder_axis_accum #(.DW(DW), .AVG_LOG2(AVG_LOG2)) u_acc_z (
        .clk(clk), .rst(rst), .add(smp_valid), .close(win_close),
        .sample(az), .avg(avg_z)
    );

    // Sample counter shared by all axes; its wrap marks the window close.
    always_ff @(posedge clk) begin
        if (rst) begin
            smp_cnt <= '0;
        end else if (smp_valid) begin
            smp_cnt <= smp_cnt + 1'b1;
        end
    end

    // Pending slot: a closing window always wins over consumption at the
    // same edge, and replacing an unconsumed average counts as an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v  <= 1'b0;
            pend_x  <= '0;
            pend_y  <= '0;
            pend_z  <= '0;
            ovr_cnt <= '0;
        end else begin
            if (win_close) begin
                pend_v <= 1'b1;
                pend_x <= avg_x;
                pend_y <= avg_y;
                pend_z <= avg_z;
                if (pend_v && !issue && (ovr_cnt != 8'hFF)) begin
                    ovr_cnt <= ovr_cnt + 8'd1;
                end
            end else if (issue) begin
                pend_v <= 1'b0;
            end
        end
    end

    // Request FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: issue whenever an average is pending, and accept done only
    // after the start cycle so a done from an earlier request cannot end this one.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pend_v) state_nxt = BUSY;
            BUSY: if (cdra_done && !cdra_start) state_nxt = IDLE;
        endcase
    end

    // Outputs to the CORDIC: one-cycle start, operands latched at issue and
    // held for the whole request.
    always_ff @(posedge clk) begin
        if (rst) begin
            cdra_start <= 1'b0;
            x          <= '0;
            y          <= '0;
            z          <= '0;
        end else begin
            cdra_start <= issue;
            if (issue) begin
                x <= pend_x;
                y <= pend_y;
                z <= pend_z;
            end
        end
    end

endmodule

// File: tb/tb_accel_avg_feeder.sv
// Directed testbench for accel_avg_feeder with default parameters
// (DW=16, AVG_LOG2=3, eight samples per window).
module tb_accel_avg_feeder;

    logic               clk = 1'b0;
    logic               rst;
    logic               smp_valid;
    logic signed [15:0] ax, ay, az;
    logic signed [15:0] x, y, z;
    logic               cdra_start;
    logic               cdra_done;
    logic               busy;
    logic [7:0]         ovr_cnt;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;

    accel_avg_feeder dut (
        .clk(clk), .rst(rst), .smp_valid(smp_valid),
        .ax(ax), .ay(ay), .az(az),
        .x(x), .y(y), .z(z),
        .cdra_start(cdra_start), .cdra_done(cdra_done),
        .busy(busy), .ovr_cnt(ovr_cnt)
    );

    // 50 MHz clock
    always #10 clk = ~clk;

    // Count every cycle in which a start request is visible.
    always @(negedge clk) begin
        if (cdra_start) start_cnt = start_cnt + 1;
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a, input int b, input int c);
        smp_valid = 1'b1;
        ax = 16'(a);
        ay = 16'(b);
        az = 16'(c);
        tick();
        smp_valid = 1'b0;
    endtask

    task automatic send_window(input int a, input int b, input int c);
        repeat (8) send(a, b, c);
    endtask

    task automatic pulse_done();
        cdra_done = 1'b1;
        tick();
        cdra_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            smp_valid = i[0];
            ax = 16'sd1234; ay = -16'sd77; az = 16'sd5;
            tick();
            checks++;
            if ({x, y, z, cdra_start, busy, ovr_cnt} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_state cycle %0d got x=%0d y=%0d z=%0d start=%b busy=%b ovr=%0d want all 0",
                         i, x, y, z, cdra_start, busy, ovr_cnt);
            end
        end
        smp_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int s0;
        for (int i = 0; i < 8; i++) send(10000, 10000, 11585);
        s0 = start_cnt;
        checks++;
        if (cdra_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_early got start=%b busy=%b want 0 0", cdra_start, busy);
        end
        tick();
        checks++;
        if (cdra_start !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_start got start=%b busy=%b want 1 1", cdra_start, busy);
        end
        checks++;
        if (x !== 16'sd10000 || y !== 16'sd10000 || z !== 16'sd11585) begin
            errors++;
            $display("[TB] FAIL basic_avg got %0d %0d %0d want 10000 10000 11585", x, y, z);
        end
        tick();
        checks++;
        if (cdra_start !== 1'b0 || busy !== 1'b1 || x !== 16'sd10000) begin
            errors++;
            $display("[TB] FAIL basic_hold got start=%b busy=%b x=%0d want 0 1 10000", cdra_start, busy, x);
        end
        repeat (3) tick();
        pulse_done();
        checks++;
        if (busy !== 1'b0 || start_cnt !== s0 + 1) begin
            errors++;
            $display("[TB] FAIL basic_done got busy=%b starts=%0d want 0 %0d", busy, start_cnt - s0, 1);
        end
    endtask

    task automatic test_floor();
        int first_v [3] = '{-1, 1, -32768};
        int rest_v  [3] = '{0, 0, -32768};
        int exp_v   [3] = '{-1, 0, -32768};
        for (int t = 0; t < 3; t++) begin
            send(first_v[t], 0, 0);
            repeat (7) send(rest_v[t], 0, 0);
            tick();
            checks++;
            if (cdra_start !== 1'b1 || x !== 16'(exp_v[t])) begin
                errors++;
                $display("[TB] FAIL floor_%0d got start=%b x=%0d want 1 %0d", t, cdra_start, x, exp_v[t]);
            end
            tick();
            pulse_done();
        end
    endtask

    task automatic test_overlap();
        int s0;
        send_window(100, 200, 300);
        s0 = start_cnt;
        tick();
        send_window(-500, 40, 7);
        repeat (31) tick();
        pulse_done();
        checks++;
        if (start_cnt !== s0 + 1 || cdra_start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overlap_wait got starts=%0d start=%b busy=%b want 1 0 0",
                     start_cnt - s0, cdra_start, busy);
        end
        tick();
        checks++;
        if (cdra_start !== 1'b1 || x !== -16'sd500 || y !== 16'sd40 || z !== 16'sd7) begin
            errors++;
            $display("[TB] FAIL overlap_issue got start=%b %0d %0d %0d want 1 -500 40 7", cdra_start, x, y, z);
        end
        checks++;
        if (ovr_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL overlap_ovr got %0d want 0", ovr_cnt);
        end
        tick();
        pulse_done();
    endtask

    task automatic test_overrun();
        send_window(1, 2, 3);
        tick();
        send_window(4, 5, 6);
        send_window(7, 8, 9);
        checks++;
        if (ovr_cnt !== 8'd1 || busy !== 1'b1 || x !== 16'sd1) begin
            errors++;
            $display("[TB] FAIL overrun_one got ovr=%0d busy=%b x=%0d want 1 1 1", ovr_cnt, busy, x);
        end
        pulse_done();
        tick();
        checks++;
        if (cdra_start !== 1'b1 || x !== 16'sd7 || y !== 16'sd8 || z !== 16'sd9) begin
            errors++;
            $display("[TB] FAIL overrun_issue got start=%b %0d %0d %0d want 1 7 8 9", cdra_start, x, y, z);
        end
        send_window(10, 11, 12);
        for (int i = 0; i < 253; i++) send_window(i, 1, 2);
        checks++;
        if (ovr_cnt !== 8'd254) begin
            errors++;
            $display("[TB] FAIL overrun_254 got %0d want 254", ovr_cnt);
        end
        send_window(20, 21, 22);
        checks++;
        if (ovr_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL overrun_255 got %0d want 255", ovr_cnt);
        end
        for (int i = 0; i < 45; i++) send_window(i, 3, 4);
        send_window(-300, 301, -302);
        checks++;
        if (ovr_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL overrun_sat got %0d want 255", ovr_cnt);
        end
        pulse_done();
        tick();
        checks++;
        if (cdra_start !== 1'b1 || x !== -16'sd300 || y !== 16'sd301 || z !== -16'sd302) begin
            errors++;
            $display("[TB] FAIL overrun_last got start=%b %0d %0d %0d want 1 -300 301 -302", cdra_start, x, y, z);
        end
        tick();
        pulse_done();
    endtask

    task automatic test_mid_reset();
        int s0;
        send_window(50, 60, 70);
        tick();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrst_busy got %b want 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({x, y, z, cdra_start, busy, ovr_cnt} !== '0) begin
            errors++;
            $display("[TB] FAIL midrst_clear got x=%0d busy=%b ovr=%0d want 0 0 0", x, busy, ovr_cnt);
        end
        s0 = start_cnt;
        pulse_done();
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0 || start_cnt !== s0) begin
            errors++;
            $display("[TB] FAIL midrst_stray got busy=%b starts=%0d want 0 0", busy, start_cnt - s0);
        end
        repeat (3) send(1000, 1000, 1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send_window(80, -80, 16);
        tick();
        checks++;
        if (cdra_start !== 1'b1 || x !== 16'sd80 || y !== -16'sd80 || z !== 16'sd16) begin
            errors++;
            $display("[TB] FAIL midrst_next got start=%b %0d %0d %0d want 1 80 -80 16", cdra_start, x, y, z);
        end
        tick();
        pulse_done();
    endtask

    initial begin
        rst = 1'b1;
        smp_valid = 1'b0;
        cdra_done = 1'b0;
        ax = '0;
        ay = '0;
        az = '0;
        test_reset();
        test_basic();
        test_floor();
        test_overlap();
        test_overrun();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
